// File: rtl/adder_response_checker_if.sv
// Vector/response/result bundle for adder_response_checker.
// The checker takes the slave view; the stimulus side takes the master view.
interface adder_response_checker_if #(
    parameter int unsigned ERR_W = 8
);
    logic             vec_valid;
    logic             vec_a;
    logic             vec_b;
    logic             vec_cin;
    logic             dut_sum;
    logic             dut_cout;
    logic             mismatch;
    logic [ERR_W-1:0] err_count;
    logic             first_fail_valid;
    logic [2:0]       first_fail_vec;
    logic [7:0]       coverage;
    logic             all_covered;
    logic             pass;

    modport master (
        output vec_valid, vec_a, vec_b, vec_cin, dut_sum, dut_cout,
        input  mismatch, err_count, first_fail_valid, first_fail_vec,
               coverage, all_covered, pass
    );

    modport slave (
        input  vec_valid, vec_a, vec_b, vec_cin, dut_sum, dut_cout,
        output mismatch, err_count, first_fail_valid, first_fail_vec,
               coverage, all_covered, pass
    );
endinterface

// File: rtl/adder_response_checker.sv
// Response checker for an adder under test: aligns each {a,b,cin} vector to the
// DUT response, compares with a golden adder and accumulates errors/coverage.
module adder_response_checker #(
    parameter int unsigned LATENCY    = 0,
    parameter bit          FULL_ADDER = 1'b1,
    parameter int unsigned ERR_W      = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    clear,
    adder_response_checker_if.slave bus
);

    logic             cmp_valid;
    logic [2:0]       cmp_vec;
    logic             exp_sum;
    logic             exp_cout;
    logic             fail;

    logic             mismatch_q;
    logic [ERR_W-1:0] err_q;
    logic             ffv_q;
    logic [2:0]       ffvec_q;
    logic [7:0]       cov_q;

    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_valid = bus.vec_valid;
            assign cmp_vec   = {bus.vec_a, bus.vec_b, bus.vec_cin};
        end else begin : g_pipe
            // Each stage is {valid, a, b, cin}; bubbles travel as valid=0.
            logic [3:0] stage [LATENCY];

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
                end else if (clear) begin
                    for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= {bus.vec_valid, bus.vec_a, bus.vec_b, bus.vec_cin};
                    for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
                end
            end

            assign cmp_valid = stage[LATENCY-1][3];
            assign cmp_vec   = stage[LATENCY-1][2:0];
        end
    endgenerate

    always_comb begin
        exp_sum  = 1'b0;
        exp_cout = 1'b0;
        if (FULL_ADDER) begin
            exp_sum  = cmp_vec[2] ^ cmp_vec[1] ^ cmp_vec[0];
            exp_cout = (cmp_vec[2] & cmp_vec[1]) | (cmp_vec[2] & cmp_vec[0]) |
                       (cmp_vec[1] & cmp_vec[0]);
        end else begin
            exp_sum  = cmp_vec[2] ^ cmp_vec[1];
            exp_cout = cmp_vec[2] & cmp_vec[1];
        end
    end

    assign fail = cmp_valid &&
                  ((bus.dut_sum != exp_sum) || (bus.dut_cout != exp_cout));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            cov_q      <= '0;
        end else if (clear) begin
            mismatch_q <= 1'b0;
            err_q      <= '0;
            ffv_q      <= 1'b0;
            ffvec_q    <= '0;
            cov_q      <= '0;
        end else begin
            mismatch_q <= fail;
            if (cmp_valid) cov_q[cmp_vec] <= 1'b1;
            if (fail) begin
                // Saturate rather than wrap so a large error burst never reads as clean.
                if (err_q != '1) err_q <= err_q + 1'b1;
                if (!ffv_q) begin
                    ffv_q   <= 1'b1;
                    ffvec_q <= cmp_vec;
                end
            end
        end
    end

    assign bus.mismatch         = mismatch_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_valid = ffv_q;
    assign bus.first_fail_vec   = ffvec_q;
    assign bus.coverage         = cov_q;
    assign bus.all_covered      = &cov_q;
    assign bus.pass             = (&cov_q) && (err_q == '0);

endmodule
